// File: rtl/encoder_pkg.sv
// Shared types, mode names and grant helper for the N-line priority encoder.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package encoder_pkg;

  // Widest request vector the encoder family supports.
  localparam int ENC_MAX_N = 64;
  localparam int ENC_MAX_W = 6;

  // Encoding modes selectable through the MODE parameter.
  localparam string ENC_MODE_FIXED = "FIXED";
  localparam string ENC_MODE_RR    = "RR";

  // Output register occupancy.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } enc_state_t;

  // One-hot vector with a single bit set at position idx.
  function automatic logic [ENC_MAX_N-1:0] onehot_of(input logic [ENC_MAX_W-1:0] idx);
    logic [ENC_MAX_N-1:0] one;
    one = {{(ENC_MAX_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority search over N lines: reverse (highest wins) or rotating from start.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the result is used.
module prio_enc_core
  import encoder_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = $clog2(N),
  parameter bit REVERSE = 1'b1
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] rot;
  logic [W-1:0] fwd_off;
  logic [W:0]   fwd_sum;
  logic [W-1:0] fwd_idx;
  logic [W-1:0] rev_idx;

  // Rotating search: shift a doubled copy so the start line lands at bit 0,
  // take the lowest set bit, then map the offset back onto the original lines.
  always_comb begin
    rot     = N'({vec, vec} >> start);
    fwd_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        fwd_off = W'(i);
      end
    end
    fwd_sum = {1'b0, start} + {1'b0, fwd_off};
    if (fwd_sum >= (W+1)'(N)) begin
      fwd_idx = W'(fwd_sum - (W+1)'(N));
    end else begin
      fwd_idx = W'(fwd_sum);
    end
  end

  // Reverse search: the last assignment in an upward scan is the highest set bit.
  always_comb begin
    rev_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        rev_idx = W'(i);
      end
    end
  end

  // Index is meaningless when nothing is set; the caller forces it to zero then.
  assign found = |vec;
  assign idx   = REVERSE ? rev_idx : fwd_idx;

endmodule

// File: rtl/encoder_nx_rr.sv
// Registered N-line priority encoder (fixed-priority or round-robin) with valid/ready on both sides.
// Latency: 1 cycle from accept to result on idx/grant/none; one vector per cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; a held result stays stable until consumed.
module encoder_nx_rr
  import encoder_pkg::*;
#(
  parameter int    N    = 8,
  parameter int    W    = $clog2(N),
  parameter string MODE = "FIXED"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         none
);

  localparam bit IS_RR = (MODE == ENC_MODE_RR);

  enc_state_t   state;
  enc_state_t   state_nxt;
  logic [W-1:0] ptr;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic         accept;
  logic         consume;
  logic [N-1:0] win_grant;

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Fixed mode scans downward from N-1; round-robin scans upward from ptr.
  // ptr stays 0 in fixed mode, so start is harmless there.
  prio_enc_core #(
    .N       (N),
    .W       (W),
    .REVERSE (!IS_RR)
  ) u_core (
    .vec   (req),
    .start (ptr),
    .idx   (win_idx),
    .found (win_found)
  );

  assign win_grant = N'(onehot_of(ENC_MAX_W'(win_idx)));

  // Occupancy register for the single output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Slot fills on accept, empties only on a consume with no refill behind it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_FULL;
      ST_FULL: if (consume && !accept) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result register; loads only on accept so the held value is stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      grant <= '0;
      none  <= 1'b1;
    end else if (accept) begin
      idx   <= win_found ? win_idx : '0;
      grant <= win_found ? win_grant : '0;
      none  <= !win_found;
    end
  end

  // Round-robin pointer advances past the winner; empty accepts leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (IS_RR && accept && win_found) begin
      ptr <= (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
    end
  end

endmodule

// File: tb/tb_encoder_nx_rr.sv
// Bench for encoder_nx_rr: FIXED and RR instances share stimulus, each with its own scoreboard.
// Latency: expected results are queued on accept and popped on consume.
// Backpressure: exercised by holding out_ready low with a pending result.
module tb_encoder_nx_rr;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] grant;
    logic       none;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_f, out_valid_f, none_f;
  logic [2:0] idx_f;
  logic [7:0] grant_f;
  logic       in_ready_r, out_valid_r, none_r;
  logic [2:0] idx_r;
  logic [7:0] grant_r;

  exp_t q_fix[$];
  exp_t q_rr[$];

  int n_checks = 0;
  int n_fail   = 0;

  encoder_nx_rr #(.N(8), .MODE("FIXED")) u_fix (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_ready(in_ready_f),
    .out_valid(out_valid_f), .out_ready(out_ready), .idx(idx_f), .grant(grant_f), .none(none_f)
  );

  encoder_nx_rr #(.N(8), .MODE("RR")) u_rr (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_ready(in_ready_r),
    .out_valid(out_valid_r), .out_ready(out_ready), .idx(idx_r), .grant(grant_r), .none(none_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] v, input int i);
    exp_t e;
    e.none  = (v == 8'h00);
    e.idx   = e.none ? 3'd0 : 3'(i);
    e.grant = e.none ? 8'h00 : (8'h01 << e.idx);
    return e;
  endfunction

  // Present v until accepted; queue the hand-computed results for both modes.
  task automatic send(input logic [7:0] v, input int fi, input int ri);
    int n;
    n = 0;
    req      = v;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready_f) break;
      n++;
      if (n > 20) begin
        check("accept_timeout", 64'(in_ready_f), 64'd1);
        break;
      end
    end
    if (in_ready_f) begin
      q_fix.push_back(mk(v, fi));
      q_rr.push_back(mk(v, ri));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fixed-mode monitor: compare every consumed result against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid_f && out_ready) begin
      if (q_fix.size() == 0) begin
        check("fix_unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q_fix.pop_front();
        check("fix_idx", 64'(idx_f), 64'(e.idx));
        check("fix_grant", 64'(grant_f), 64'(e.grant));
        check("fix_none", 64'(none_f), 64'(e.none));
      end
    end
  end

  // Round-robin monitor.
  always @(negedge clk) begin
    if (!rst && out_valid_r && out_ready) begin
      if (q_rr.size() == 0) begin
        check("rr_unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q_rr.pop_front();
        check("rr_idx", 64'(idx_r), 64'(e.idx));
        check("rr_grant", 64'(grant_r), 64'(e.grant));
        check("rr_none", 64'(none_r), 64'(e.none));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;

    // Reset held three cycles with in_valid asserted.
    repeat (3) begin
      @(negedge clk);
      check("rst_fix_out_valid", 64'(out_valid_f), 64'd0);
      check("rst_rr_out_valid", 64'(out_valid_r), 64'd0);
      check("rst_rr_none", 64'(none_r), 64'd1);
      check("rst_rr_ptr", 64'(u_rr.ptr), 64'd0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready_r), 64'd1);
    check("post_rst_out_valid", 64'(out_valid_r), 64'd0);
    check("post_rst_none", 64'(none_f), 64'd1);
    check("post_rst_grant", 64'(grant_f), 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back vectors; RR pointer path: 0 -> 2 -> 1 -> 1 -> 0.
    send(8'h96, 7, 1);
    send(8'h01, 0, 0);
    send(8'h00, 0, 0);
    send(8'h80, 7, 7);
    check("rr_ptr_after_80", 64'(u_rr.ptr), 64'd0);

    // 0x11 four times from ptr 0: RR alternates 0,4,0,4.
    send(8'h11, 4, 0);
    send(8'h11, 4, 4);
    send(8'h11, 4, 0);
    send(8'h11, 4, 4);
    check("rr_ptr_after_11s", 64'(u_rr.ptr), 64'd5);
    send(8'h80, 7, 7);
    check("rr_ptr_wrap_from_7", 64'(u_rr.ptr), 64'd0);
    check("fix_ptr_stays_0", 64'(u_fix.ptr), 64'd0);

    // Set ptr to 7, then wrap across the top.
    send(8'h40, 6, 6);
    check("rr_ptr_7", 64'(u_rr.ptr), 64'd7);
    send(8'h03, 1, 0);
    check("rr_ptr_after_wrap", 64'(u_rr.ptr), 64'd1);
    idle(1);

    // Backpressure: one accept, then four stalled cycles with a new vector waiting.
    out_ready = 1'b0;
    send(8'h24, 5, 2);
    req      = 8'hFF;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready_r), 64'd0);
      check("bp_out_valid", 64'(out_valid_r), 64'd1);
      check("bp_fix_idx_hold", 64'(idx_f), 64'd5);
      check("bp_rr_idx_hold", 64'(idx_r), 64'd2);
      check("bp_rr_grant_hold", 64'(grant_r), 64'h04);
      check("bp_rr_ptr_hold", 64'(u_rr.ptr), 64'd3);
    end
    @(posedge clk);
    #1;
    // Release with a vector waiting: accept and consume on the same edge.
    out_ready = 1'b1;
    send(8'h18, 4, 3);
    check("ac_out_valid", 64'(out_valid_r), 64'd1);
    check("ac_queue_depth", 64'(q_rr.size()), 64'd1);
    check("ac_rr_ptr", 64'(u_rr.ptr), 64'd4);
    idle(1);

    // Mid-operation reset with ptr 3 and a held result.
    out_ready = 1'b0;
    send(8'h04, 2, 2);
    check("mr_rr_ptr_before", 64'(u_rr.ptr), 64'd3);
    check("mr_out_valid_before", 64'(out_valid_r), 64'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    req      = 8'hFF;
    q_fix.delete();
    q_rr.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_out_valid", 64'(out_valid_r), 64'd0);
    check("mr_rr_ptr", 64'(u_rr.ptr), 64'd0);
    check("mr_none", 64'(none_r), 64'd1);
    check("mr_in_ready", 64'(in_ready_r), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h0A, 3, 1);
    check("mr_rr_ptr_after", 64'(u_rr.ptr), 64'd2);
    idle(3);
    check("fix_queue_drained", 64'(q_fix.size()), 64'd0);
    check("rr_queue_drained", 64'(q_rr.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
